// File: rtl/mul8_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The operand width is fixed by the adder8bit datapath.
package mul8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int         OP_W      = 8;
  localparam int         PROD_W    = 16;
  localparam logic [2:0] LAST_STEP = 3'd7;

endpackage

// File: rtl/adder8bit.sv
// 8-bit ripple-carry adder: the lab datapath adder reused by the multiplier.
module adder8bit (
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       Cin,
  output logic [7:0] Sum,
  output logic       Cout
);

  logic [8:0] carry_s;

  assign carry_s[0] = Cin;

  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign Sum[i]       = A[i] ^ B[i] ^ carry_s[i];
    assign carry_s[i+1] = (A[i] & B[i]) | (carry_s[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry_s[8];

endmodule

// File: rtl/mul8_shift_add.sv
// Sequential 8x8 unsigned multiplier: one adder8bit step per cycle over
// eight cycles, with valid/ready handshakes on the operand and product sides.
module mul8_shift_add
  import mul8_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_W-1:0]     a,
  input  logic [OP_W-1:0]     b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PROD_W-1:0]   product
);

  mul_state_t        state_r;
  logic [OP_W-1:0]   m_r;
  logic [PROD_W-1:0] p_r;
  logic [2:0]        cnt_r;

  logic [OP_W-1:0]   addend_s;
  logic [OP_W-1:0]   sum_s;
  logic              cout_s;

  // Upper half of P is the accumulator; Q[0] selects whether M is added.
  assign addend_s = p_r[0] ? m_r : 8'h00;

  adder8bit u_adder (
    .A    (p_r[PROD_W-1:OP_W]),
    .B    (addend_s),
    .Cin  (1'b0),
    .Sum  (sum_s),
    .Cout (cout_s)
  );

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign product   = p_r;

  // Handshake FSM and shift-and-add datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      m_r     <= 8'h00;
      p_r     <= 16'h0000;
      cnt_r   <= 3'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            m_r     <= a;
            p_r     <= {8'h00, b};
            cnt_r   <= 3'd0;
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          // The 17-bit {Cout, Sum, Q} shifted right keeps the carry in P.
          p_r   <= {cout_s, sum_s, p_r[OP_W-1:1]};
          cnt_r <= cnt_r + 3'd1;
          if (cnt_r == LAST_STEP) begin
            state_r <= DONE;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
